// File: rtl/letter_fifo.sv
// Letter buffer between the enigma encoder and the IR transmitter: circular store with
// stream/packet release. Define LETTER_FIFO_OVERWRITE_EN to make a write into a full buffer evict the oldest entry.
module letter_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 1000,
  parameter int GROUP = 5
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       mode_in,
  input  logic                       flush_in,
  input  logic                       data_valid_in,
  input  logic [WIDTH-1:0]           data_in,
  output logic                       full_out,
  output logic                       data_valid_out,
  input  logic                       data_ready_in,
  output logic [WIDTH-1:0]           data_out,
  output logic [$clog2(DEPTH+1)-1:0] count_out,
  output logic                       overflow_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] GROUP_C = CW'(GROUP);
  localparam logic [PW-1:0] LAST_C  = PW'(DEPTH-1);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_next;
  logic [CW-1:0] avail;
  logic          latch_reg, latch_next;
  logic          pop, push, drop, full_now, overflow_hit;

  always_comb begin
    pop          = data_valid_out && data_ready_in;
    full_now     = (count_out == DEPTH_C);
    overflow_hit = data_valid_in && full_now && !pop;
    push         = data_valid_in && (!full_now || pop);
    drop         = 1'b0;
`ifdef LETTER_FIFO_OVERWRITE_EN
    if (overflow_hit) begin
      push = 1'b1;
      drop = 1'b1;
    end
`endif

    wr_ptr_next = wr_ptr_reg;
    if (push) begin
      wr_ptr_next = (wr_ptr_reg == LAST_C) ? '0 : wr_ptr_reg + PW'(1);
    end
    rd_ptr_next = rd_ptr_reg;
    if (pop || drop) begin
      rd_ptr_next = (rd_ptr_reg == LAST_C) ? '0 : rd_ptr_reg + PW'(1);
    end

    // Entries written before this edge that survive it; only these may be offered next.
    avail      = count_out - CW'(pop) - CW'(drop);
    count_next = avail + CW'(push);

    latch_next = latch_reg;
    if (count_next == '0) begin
      latch_next = 1'b0;
    end else if (count_next >= GROUP_C) begin
      latch_next = 1'b1;
    end else if (flush_in && (count_out != '0)) begin
      latch_next = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      mem[wr_ptr_reg] <= data_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_out      <= '0;
      full_out       <= 1'b0;
      overflow_out   <= 1'b0;
      latch_reg      <= 1'b0;
      data_valid_out <= 1'b0;
      data_out       <= '0;
    end else begin
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      count_out      <= count_next;
      full_out       <= (count_next == DEPTH_C);
      overflow_out   <= overflow_out | overflow_hit;
      latch_reg      <= latch_next;
      data_valid_out <= (avail != '0) && (!mode_in || latch_reg);
      // The head slot was written on an earlier edge, so a plain registered read suffices.
      if (avail != '0) begin
        data_out <= mem[rd_ptr_next];
      end
    end
  end

endmodule

// File: tb/tb_letter_fifo.sv
// Randomised bench for letter_fifo against a queue-based reference model.
module tb_letter_fifo;
  localparam int WIDTH = 5;
  localparam int DEPTH = 5;
  localparam int GROUP = 5;
  localparam int CW    = $clog2(DEPTH+1);

  logic             clk_100_passthrough = 1'b0;
  logic             rst_n = 1'b1;
  logic             mode = 1'b0;
  logic             flush = 1'b0;
  logic             dvi = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             full;
  logic             dvo;
  logic             ready = 1'b0;
  logic [WIDTH-1:0] dout;
  logic [CW-1:0]    count;
  logic             ovf;

  always #5 clk_100_passthrough = ~clk_100_passthrough;

  letter_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .GROUP(GROUP)) u_dut (
    .clk_in         (clk_100_passthrough),
    .rst_in         (rst_n),
    .mode_in        (mode),
    .flush_in       (flush),
    .data_valid_in  (dvi),
    .data_in        (din),
    .full_out       (full),
    .data_valid_out (dvo),
    .data_ready_in  (ready),
    .data_out       (dout),
    .count_out      (count),
    .overflow_out   (ovf)
  );

  int checks = 0;
  int failures = 0;

  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] seen[$];
  bit exp_valid = 1'b0;
  bit exp_ovf = 1'b0;
  bit exp_latch = 1'b0;
  bit last_push = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Behaviour at one clock edge, expressed on a queue of stored symbols.
  task automatic model_edge();
    logic [WIDTH-1:0] tmp;
    int  old_size;
    int  avail;
    bit  pop;
    bit  push;
    old_size = q.size();
    pop  = exp_valid && ready;
    push = 1'b0;
    if (pop) tmp = q.pop_front();
    if (dvi) begin
      if (old_size < DEPTH || pop) begin
        push = 1'b1;
      end else begin
        exp_ovf = 1'b1;
`ifdef LETTER_FIFO_OVERWRITE_EN
        tmp  = q.pop_front();
        push = 1'b1;
`endif
      end
    end
    avail = q.size();
    if (push) q.push_back(din);
    exp_valid = (avail > 0) && (!mode || exp_latch);
    if (q.size() == 0) exp_latch = 1'b0;
    else if (q.size() >= GROUP) exp_latch = 1'b1;
    else if (flush && old_size > 0) exp_latch = 1'b1;
    last_push = push;
  endtask

  task automatic step();
    if (dvo && ready) seen.push_back(dout);
    @(posedge clk_100_passthrough);
    model_edge();
    #1;
    check("valid", dvo, exp_valid);
    check("count", count, q.size());
    check("full", full, q.size() == DEPTH);
    check("overflow", ovf, exp_ovf);
    if (exp_valid) check("data", dout, q[0]);
    $display("cyc dvi=%0b din=%0d rdy=%0b mode=%0b flush=%0b -> valid=%0b dout=%0d count=%0d ovf=%0b",
             dvi, din, ready, mode, flush, dvo, dout, count, ovf);
  endtask

  task automatic idle(input int n);
    dvi = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic put(input logic [WIDTH-1:0] v);
    dvi = 1'b1;
    din = v;
    step();
    dvi = 1'b0;
  endtask

  // Assert reset between edges, check outputs drop at once, then release between edges.
  task automatic do_reset();
    dvi = 1'b0;
    flush = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_valid", dvo, 0);
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_ovf", ovf, 0);
    check("rst_data", dout, 0);
    q.delete();
    exp_valid = 1'b0;
    exp_ovf = 1'b0;
    exp_latch = 1'b0;
    @(posedge clk_100_passthrough);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int stream_vals[3];
    int sym;
    int base;
    stream_vals = '{3, 7, 12};

    #2;
    do_reset();

    // Stream basic
    mode = 1'b0;
    ready = 1'b1;
    seen.delete();
    for (int i = 0; i < 3; i++) put(WIDTH'(stream_vals[i]));
    idle(4);
    check("stream_count0", count, 0);
    check("stream_len", seen.size(), 3);
    for (int i = 0; i < 3 && i < seen.size(); i++) check("stream_order", seen[i], stream_vals[i]);

    // Packet hold, threshold release, then flush release
    do_reset();
    mode = 1'b1;
    ready = 1'b1;
    for (int i = 0; i < 4; i++) put(WIDTH'($urandom));
    idle(2);
    check("pkt_hold_valid", dvo, 0);
    check("pkt_hold_count", count, 4);
    put(WIDTH'($urandom));
    idle(7);
    check("pkt_drained", count, 0);
    put(WIDTH'($urandom));
    put(WIDTH'($urandom));
    idle(2);
    check("pkt_pre_flush", dvo, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle(4);
    check("flush_drained", count, 0);

    // Full and overflow
    do_reset();
    mode = 1'b0;
    ready = 1'b0;
    for (int i = 1; i <= DEPTH + 1; i++) put(WIDTH'(i));
    check("full_flag", full, 1);
    check("full_count", count, DEPTH);
    check("full_ovf", ovf, 1);
    seen.delete();
    ready = 1'b1;
    idle(DEPTH + 2);
`ifdef LETTER_FIFO_OVERWRITE_EN
    base = 2;
`else
    base = 1;
`endif
    check("full_drain_len", seen.size(), DEPTH);
    for (int i = 0; i < seen.size(); i++) check("full_drain", seen[i], base + i);

    // Simultaneous push and pop while full
    do_reset();
    ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) put(WIDTH'($urandom_range(0, 8)));
    idle(1);
    check("pp_valid", dvo, 1);
    seen.delete();
    ready = 1'b1;
    put(WIDTH'(9));
    check("pp_count", count, DEPTH);
    check("pp_ovf", ovf, 0);
    idle(DEPTH + 1);
    check("pp_last", seen.size() > 0 ? seen[seen.size()-1] : 0, 9);

    // Wrap-around with random back-pressure
    do_reset();
    mode = 1'b0;
    seen.delete();
    sym = 0;
    for (int c = 0; c < 300 && seen.size() < 12; c++) begin
      ready = 1'($urandom_range(0, 1));
      dvi = (sym < 12);
      din = WIDTH'(sym);
      step();
      if (last_push) sym++;
    end
    dvi = 1'b0;
    check("wrap_len", seen.size(), 12);
    for (int i = 0; i < seen.size(); i++) check("wrap_order", seen[i], i);

    // Fully random traffic with mode switches and flushes
    do_reset();
    for (int c = 0; c < 500; c++) begin
      dvi = ($urandom_range(0, 3) != 0);
      din = WIDTH'($urandom);
      ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      step();
    end
    dvi = 1'b0;
    flush = 1'b0;

    // Asynchronous reset in the middle of a drain
    mode = 1'b0;
    ready = 1'b0;
    idle(1);
    for (int i = 0; i < 3; i++) put(WIDTH'(i + 4));
    ready = 1'b1;
    idle(2);
    do_reset();
    ready = 1'b0;
    put(WIDTH'(21));
    step();
    check("post_rst_valid", dvo, 1);
    check("post_rst_data", dout, 21);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
